// File: rtl/fc_ctrl_pkg.sv
// Shared types and helpers for the fully-connected classifier sequencer.
//   - fc_state_e    : sequencer FSM states
//   - total_weights : number of weights across the whole network
//   - in_base       : activation base address of a layer's inputs
//   - relu          : max(0, v) on a sign-extended value
package fc_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StMac,
    StDrain,
    StWb,
    StDone
  } fc_state_e;

  function automatic int unsigned total_weights(input int unsigned l1, input int unsigned l2,
                                                input int unsigned l3);
    return l1 * l2 + l2 * l3;
  endfunction

  // Layer 0 reads the network inputs at 0; layer 1 reads the hidden activations stored after them.
  function automatic int unsigned in_base(input logic layer, input int unsigned l1);
    return layer ? l1 : 0;
  endfunction

  function automatic logic signed [31:0] relu(input logic signed [31:0] v);
    return (v < 0) ? '0 : v;
  endfunction

endpackage

// File: rtl/fc_argmax.sv
// Running arg-max tracker for the output layer.
//   clk_i, rst_ni : clock, async active-low reset
//   upd_i         : a new candidate value is presented
//   first_i       : candidate is the first of the run; it loads unconditionally
//   val_i, idx_i  : candidate value (signed) and its class index
//   max_idx_o     : index of the largest value seen so far
// Strict greater-than keeps the lowest index on ties.
module fc_argmax #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     upd_i,
  input  logic                     first_i,
  input  logic signed [DATA_W-1:0] val_i,
  input  logic [IDX_W-1:0]         idx_i,
  output logic [IDX_W-1:0]         max_idx_o
);

  logic signed [DATA_W-1:0] max_q, max_d;
  logic [IDX_W-1:0]         idx_q, idx_d;

  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    if (upd_i && (first_i || (val_i > max_q))) begin
      max_d = val_i;
      idx_d = idx_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_q <= '0;
      idx_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end

  assign max_idx_o = idx_q;

endmodule

// File: rtl/fc_controller.sv
// Sequencer for the three-layer FC classifier driving a shared single-MAC datapath.
//   clk_i, rst_ni   : clock, async active-low reset
//   enable_i        : start request (sampled in idle); dropping it in done returns to idle
//   mac_acc_i       : signed accumulator value from the MAC
//   rd_en_o, w_addr_o, a_addr_o : weight/activation read strobe and addresses
//   mac_clear_o, mac_en_o       : accumulator clear / accumulate (rd_en delayed one cycle)
//   act_wr_en_o, act_wr_addr_o, act_wr_data_o : hidden activation writeback
//   finished_o, result_o        : run complete, arg-max class index
// Build option: define FC_RELU_EN to write back max(0, acc) instead of the raw accumulator.
// All outputs are registered; the strobe/address registers are loaded from the next state.
module fc_controller
  import fc_ctrl_pkg::*;
#(
  parameter int unsigned L1_NODES = 3,
  parameter int unsigned L2_NODES = 2,
  parameter int unsigned L3_NODES = 10,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic signed [DATA_W-1:0] mac_acc_i,
  output logic                     rd_en_o,
  output logic [ADDR_W-1:0]        w_addr_o,
  output logic [ADDR_W-1:0]        a_addr_o,
  output logic                     mac_clear_o,
  output logic                     mac_en_o,
  output logic                     act_wr_en_o,
  output logic [ADDR_W-1:0]        act_wr_addr_o,
  output logic [DATA_W-1:0]        act_wr_data_o,
  output logic                     finished_o,
  output logic [3:0]               result_o
);

  localparam logic [ADDR_W-1:0] L1A     = ADDR_W'(L1_NODES);
  localparam logic [ADDR_W-1:0] L2A     = ADDR_W'(L2_NODES);
  localparam logic [ADDR_W-1:0] L3A     = ADDR_W'(L3_NODES);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
  localparam int unsigned       TotalW  = total_weights(L1_NODES, L2_NODES, L3_NODES);

  fc_state_e         state_q, state_d;
  logic              layer_q, layer_d;
  logic [ADDR_W-1:0] node_q, node_d;
  logic [ADDR_W-1:0] in_idx_q, in_idx_d;   // index of the read currently on the bus
  logic [ADDR_W-1:0] w_cnt_q, w_cnt_d;     // next weight address to issue
  logic [ADDR_W-1:0] n_in, n_nodes;

  logic              rd_en_d, mac_clear_d, mac_en_d, act_wr_en_d, finished_d;
  logic [ADDR_W-1:0] w_addr_d, a_addr_d, act_wr_addr_d;
  logic [DATA_W-1:0] act_wr_data_d, wb_data;
  logic              wb_hidden, wb_output;

  assign n_in    = layer_q ? L2A : L1A;
  assign n_nodes = layer_q ? L3A : L2A;

  // State and walk counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      layer_q  <= 1'b0;
      node_q   <= '0;
      in_idx_q <= '0;
      w_cnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      node_q   <= node_d;
      in_idx_q <= in_idx_d;
      w_cnt_q  <= w_cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    node_d   = node_q;
    in_idx_d = in_idx_q;
    w_cnt_d  = w_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d = StClear;
          layer_d = 1'b0;
          node_d  = '0;
          w_cnt_d = '0;
        end
      end
      StClear: begin
        state_d  = StMac;
        in_idx_d = '0;
        w_cnt_d  = w_cnt_q + AddrOne;
      end
      StMac: begin
        if (in_idx_q == n_in - AddrOne) begin
          state_d = StDrain;
        end else begin
          in_idx_d = in_idx_q + AddrOne;
          w_cnt_d  = w_cnt_q + AddrOne;
        end
      end
      StDrain: state_d = StWb;
      StWb: begin
        state_d = StClear;
        if (node_q == n_nodes - AddrOne) begin
          node_d = '0;
          if (layer_q) begin
            state_d = StDone;
          end else begin
            layer_d = 1'b1;
          end
        end else begin
          node_d = node_q + AddrOne;
        end
      end
      StDone: begin
        if (!enable_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef FC_RELU_EN
  assign wb_data = DATA_W'(relu(32'(mac_acc_i)));
`else
  assign wb_data = mac_acc_i;
`endif

  assign wb_hidden = (state_q == StWb) && !layer_q;
  assign wb_output = (state_q == StWb) && layer_q;

  // Output next values
  always_comb begin
    rd_en_d       = (state_d == StMac);
    mac_clear_d   = (state_d == StClear);
    finished_d    = (state_d == StDone);
    mac_en_d      = rd_en_o;
    w_addr_d      = w_addr_o;
    a_addr_d      = a_addr_o;
    act_wr_en_d   = wb_hidden;
    act_wr_addr_d = act_wr_addr_o;
    act_wr_data_d = act_wr_data_o;
    if (rd_en_d) begin
      w_addr_d = w_cnt_q;
      a_addr_d = ADDR_W'(in_base(layer_q, L1_NODES)) + in_idx_d;
    end
    // The accumulator is final during WB, so the write lands the cycle after.
    if (wb_hidden) begin
      act_wr_addr_d = L1A + node_q;
      act_wr_data_d = wb_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_en_o       <= 1'b0;
      w_addr_o      <= '0;
      a_addr_o      <= '0;
      mac_clear_o   <= 1'b0;
      mac_en_o      <= 1'b0;
      act_wr_en_o   <= 1'b0;
      act_wr_addr_o <= '0;
      act_wr_data_o <= '0;
      finished_o    <= 1'b0;
    end else begin
      rd_en_o       <= rd_en_d;
      w_addr_o      <= w_addr_d;
      a_addr_o      <= a_addr_d;
      mac_clear_o   <= mac_clear_d;
      mac_en_o      <= mac_en_d;
      act_wr_en_o   <= act_wr_en_d;
      act_wr_addr_o <= act_wr_addr_d;
      act_wr_data_o <= act_wr_data_d;
      finished_o    <= finished_d;
    end
  end

  fc_argmax #(
    .DATA_W(DATA_W),
    .IDX_W (4)
  ) u_argmax (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .upd_i    (wb_output),
    .first_i  (node_q == '0),
    .val_i    (mac_acc_i),
    .idx_i    (node_q[3:0]),
    .max_idx_o(result_o)
  );

  // The linear weight walk must stay inside the network's weight block.
  a_w_addr_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    rd_en_o |-> (int'(w_addr_o) < TotalW));

endmodule

// File: tb/tb_fc_controller.sv
module tb_fc_controller;

  localparam int AW = 8;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b0;
  logic signed [DW-1:0] mac_acc;
  logic                 rd_en, mac_clear, mac_en, act_wr_en, finished;
  logic [AW-1:0]        w_addr, a_addr, act_wr_addr;
  logic [DW-1:0]        act_wr_data;
  logic [3:0]           result;

  always #5 clk = ~clk;

  fc_controller #(
    .L1_NODES(3),
    .L2_NODES(2),
    .L3_NODES(10),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .mac_acc_i    (mac_acc),
    .rd_en_o      (rd_en),
    .w_addr_o     (w_addr),
    .a_addr_o     (a_addr),
    .mac_clear_o  (mac_clear),
    .mac_en_o     (mac_en),
    .act_wr_en_o  (act_wr_en),
    .act_wr_addr_o(act_wr_addr),
    .act_wr_data_o(act_wr_data),
    .finished_o   (finished),
    .result_o     (result)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- Memories + MAC environment model ----------------
  logic signed [15:0] xmem [3];
  logic signed [15:0] wmem [26];
  logic signed [15:0] hmem [2];
  logic signed [15:0] rw_q, ra_q;
  logic signed [15:0] acc = '0;
  logic               preset_mode = 1'b0;
  int                 pre [12];
  int                 pidx = 0;

  function automatic logic signed [15:0] rd_w(input logic [7:0] a);
    return (a < 8'd26) ? wmem[a[4:0]] : 16'sd0;
  endfunction

  function automatic logic signed [15:0] rd_a(input logic [7:0] a);
    if (a < 8'd3) return xmem[a[1:0]];
    if (a == 8'd3) return hmem[0];
    if (a == 8'd4) return hmem[1];
    return 16'sd0;
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      rw_q <= rd_w(w_addr);
      ra_q <= rd_a(a_addr);
    end
    if (act_wr_en && act_wr_addr == 8'd3) hmem[0] <= act_wr_data;
    if (act_wr_en && act_wr_addr == 8'd4) hmem[1] <= act_wr_data;
    if (!enable) pidx <= 0;
    if (mac_clear) begin
      // Preset mode: the accumulator simply holds a chosen per-node value.
      if (preset_mode && pidx < 12) begin
        acc  <= 16'(pre[pidx]);
        pidx <= pidx + 1;
      end else begin
        acc <= '0;
      end
    end else if (mac_en && !preset_mode) begin
      acc <= acc + rw_q * ra_q;
    end
  end

  assign mac_acc = acc;

  // ---------------- Bus monitor ----------------
  logic [7:0]  wlog [64];
  logic [7:0]  alog [64];
  logic [7:0]  awlog [4];
  logic [15:0] adlog [4];
  int          nw = 0;
  int          naw = 0;

  always @(negedge clk) begin
    if (!enable) begin
      nw  <= 0;
      naw <= 0;
    end else begin
      if (rd_en && nw < 64) begin
        wlog[nw] <= w_addr;
        alog[nw] <= a_addr;
        nw       <= nw + 1;
      end
      if (act_wr_en && naw < 4) begin
        awlog[naw] <= act_wr_addr;
        adlog[naw] <= act_wr_data;
        naw        <= naw + 1;
      end
    end
  end

  // ---------------- Reference expectations ----------------
  logic [15:0] exp_hw [2];

  function automatic logic [15:0] wb_model(input logic signed [15:0] v);
`ifdef FC_RELU_EN
    return (v < 0) ? 16'd0 : v;
`else
    return v;
`endif
  endfunction

  // Activation address expected for the k-th read of the run.
  function automatic int exp_a(input int k);
    if (k < 6) return k % 3;
    return 3 + (k - 6) % 2;
  endfunction

  task automatic start_and_wait(output int cyc);
    @(posedge clk);
    #1 enable = 1'b1;
    @(posedge clk);  // enable-sampling edge
    #1;
    cyc = 0;
    while (!finished && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_run(input string tag, input int cyc, input int exp_res);
    int wbad, abad;
    wbad = 0;
    abad = 0;
    check({tag, " cycles"}, cyc, 62);
    check({tag, " result"}, result, exp_res);
    check({tag, " reads"}, nw, 26);
    for (int k = 0; k < 26; k++) begin
      if (wlog[k] !== 8'(k)) wbad++;
      if (alog[k] !== 8'(exp_a(k))) abad++;
    end
    check({tag, " w_addr seq errors"}, wbad, 0);
    check({tag, " a_addr seq errors"}, abad, 0);
    check({tag, " act writes"}, naw, 2);
    check({tag, " act_wr_addr0"}, awlog[0], 3);
    check({tag, " act_wr_addr1"}, awlog[1], 4);
    check({tag, " act_wr_data0"}, adlog[0], exp_hw[0]);
    check({tag, " act_wr_data1"}, adlog[1], exp_hw[1]);
  endtask

  task automatic end_run(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " finished held"}, finished, 1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " finished drop"}, finished, 0);
    check({tag, " idle rd_en"}, rd_en, 0);
  endtask

  task automatic randomize_net();
    int r;
    for (int i = 0; i < 3; i++) begin
      r = int'($urandom_range(15, 0));
      xmem[i] = 16'(r - 8);
    end
    for (int i = 0; i < 26; i++) begin
      r = int'($urandom_range(15, 0));
      wmem[i] = 16'(r - 8);
    end
  endtask

  // Plain-arithmetic evaluation of the network; returns the expected class.
  function automatic int model_net();
    int s, best;
    int o [10];
    logic signed [15:0] v16;
    for (int j = 0; j < 2; j++) begin
      s = 0;
      for (int i = 0; i < 3; i++) s += int'(wmem[j * 3 + i]) * int'(xmem[i]);
      v16 = 16'(s);
      exp_hw[j] = wb_model(v16);
    end
    for (int k = 0; k < 10; k++) begin
      s = 0;
      for (int j = 0; j < 2; j++) s += int'(wmem[6 + k * 2 + j]) * int'($signed(exp_hw[j]));
      v16 = 16'(s);
      o[k] = int'(v16);
    end
    best = 0;
    for (int k = 1; k < 10; k++) if (o[k] > o[best]) best = k;
    return best;
  endfunction

  // ---------------- Directed table (preset accumulator values) ----------------
  typedef struct packed {
    logic signed [15:0] h0;
    logic signed [15:0] h1;
    logic [159:0]       o;    // class 0 in the most significant slot
    logic [3:0]         res;
  } vec_t;

  vec_t tbl [6];

  function automatic int get_o(input logic [159:0] o, input int k);
    logic signed [15:0] v;
    v = o[16 * (9 - k) +: 16];
    return int'(v);
  endfunction

  initial begin
    int cyc, eres;
    logic [48:0] outs;

    tbl[0] = '{h0: -16'sd5, h1: 16'sd7,
               o: {16'sd3, 16'sd3, 16'sd3, 16'sd3, 16'sd3, 16'sd3, 16'sd3, 16'sd3, 16'sd3, 16'sd3},
               res: 4'd0};
    tbl[1] = '{h0: 16'sd9, h1: -16'sd1,
               o: {16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd100, 16'sd8, 16'sd9},
               res: 4'd7};
    tbl[2] = '{h0: 16'sd0, h1: 16'sd0,
               o: {-16'sd3, -16'sd2, -16'sd1, 16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5,
                   16'sd200},
               res: 4'd9};
    tbl[3] = '{h0: 16'sd300, h1: -16'sd300,
               o: {16'sd500, -16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8,
                   16'sd499},
               res: 4'd0};
    tbl[4] = '{h0: 16'sd1, h1: 16'sd2,
               o: {-16'sd10, -16'sd10, 16'sd50, -16'sd10, -16'sd10, 16'sd50, -16'sd10, -16'sd10,
                   -16'sd10, -16'sd10},
               res: 4'd2};
    tbl[5] = '{h0: -16'sd2, h1: -16'sd32768,
               o: {-16'sd100, -16'sd50, -16'sd7, -16'sd8, -16'sd7, -16'sd200, -16'sd9, -16'sd7,
                   -16'sd300, -16'sd400},
               res: 4'd2};

    // Reset held low: every output at its reset value.
    repeat (3) @(posedge clk);
    #1;
    outs = {rd_en, w_addr, a_addr, mac_clear, mac_en, act_wr_en, act_wr_addr, act_wr_data,
            finished, result};
    check("reset outputs", outs, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle rd_en", rd_en, 0);
    check("idle finished", finished, 0);
    check("idle mac_clear", mac_clear, 0);

    // Directed arg-max / writeback vectors.
    preset_mode = 1'b1;
    for (int t = 0; t < 6; t++) begin
      pre[0] = int'(tbl[t].h0);
      pre[1] = int'(tbl[t].h1);
      for (int k = 0; k < 10; k++) pre[2 + k] = get_o(tbl[t].o, k);
      exp_hw[0] = wb_model(tbl[t].h0);
      exp_hw[1] = wb_model(tbl[t].h1);
      start_and_wait(cyc);
      check_run($sformatf("vec%0d", t), cyc, int'(tbl[t].res));
      end_run($sformatf("vec%0d", t));
    end

    // Randomized networks through the modelled MAC.
    preset_mode = 1'b0;
    for (int t = 0; t < 6; t++) begin
      randomize_net();
      eres = model_net();
      start_and_wait(cyc);
      check_run($sformatf("rnd%0d", t), cyc, eres);
      end_run($sformatf("rnd%0d", t));
    end

    // Reset asserted mid-run, then a clean restart.
    randomize_net();
    @(posedge clk);
    #1 enable = 1'b1;
    @(posedge clk);  // enable-sampling edge
    repeat (20) @(posedge clk);
    #1;
    check("cycle20 w_addr", w_addr, 9);
    check("cycle20 mac_en", mac_en, 1);
    #1 rst_n = 1'b0;
    #1;
    outs = {rd_en, w_addr, a_addr, mac_clear, mac_en, act_wr_en, act_wr_addr, act_wr_data,
            finished, result};
    check("midrun reset outputs", outs, 0);
    enable = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    eres = model_net();
    start_and_wait(cyc);
    check_run("restart", cyc, eres);
    end_run("restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_controller.md
# fc_controller

Sequencer for the fully-connected classifier stage. It walks a three-layer FC network node by node and drives a shared single-MAC datapath: weight and activation read addresses, accumulator clear and enable, hidden-activation writeback. It tracks the running arg-max of the output layer and reports the winning class index with a `finished` flag. It sits between the FC weight/activation memories and the MAC unit, directly under the FC top level.

## Interface
- `L1_NODES`, 3, input-layer width
- `L2_NODES`, 2, hidden-layer width
- `L3_NODES`, 10, output-layer width (≤16)
- `ADDR_W`, 8, weight/activation address width
- `DATA_W`, 16, signed accumulator/activation width

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `enable`  in  1  start request, sampled in IDLE
- `mac_acc`  in  DATA_W  signed MAC accumulator value
- `rd_en`  out  1  weight/activation memory read strobe
- `w_addr`  out  ADDR_W  weight read address
- `a_addr`  out  ADDR_W  activation read address
- `mac_clear`  out  1  zero the accumulator
- `mac_en`  out  1  accumulate returned data (rd_en delayed 1 cycle)
- `act_wr_en`  out  1  hidden activation write strobe
- `act_wr_addr`  out  ADDR_W  activation write address
- `act_wr_data`  out  DATA_W  activation write data
- `finished`  out  1  network done, result valid
- `result`  out  4  arg-max class index

## Operation
- FSM states: IDLE, CLEAR, MAC, DRAIN, WB, DONE.
- IDLE: if `enable`=1, go to CLEAR. Set layer=0, node=0, w_addr counter=0.
- CLEAR: `mac_clear`=1 for one cycle, then go to MAC with in_idx=0.
- MAC: drive `rd_en`=1, `w_addr`=running counter, `a_addr`=in_base+in_idx. Increment both each cycle. After in_idx=N_in−1, go to DRAIN.
- DRAIN: one cycle so the last `mac_en` lands. Then go to WB.
- WB, hidden layer: `act_wr_en`=1, `act_wr_addr`=L1_NODES+node.
- WB, output layer: update arg-max.
- After WB: go to the next node (CLEAR). At the last node, go to the next layer. After the output layer, go to DONE.
- Layer 0: N_in=L1_NODES, in_base=0. Layer 1: N_in=L2_NODES, in_base=L1_NODES.
- Weight addresses run linearly across the whole network: layer_base + node·N_in + i.
- Arg-max uses a signed compare with strict `>`, so on ties the lowest index wins. The first output node always loads the max.
- DONE: `finished`=1 and `result` held. Stays until `enable`=0, then goes to IDLE.
- `enable` changes outside IDLE and DONE are ignored.

## Timing
- Reset values: all strobes 0, all addresses 0, `act_wr_data`=0, `finished`=0, `result`=0, state IDLE.
- Reset is asynchronous: any mid-run assertion forces reset values immediately. There is no resume; the next `enable` restarts from address 0.
- Memory read latency is 1 cycle. `mac_en` = `rd_en` registered.
- `mac_acc` is sampled in WB, one cycle after the last `mac_en`.
- Per-node cost is N_in+3 cycles.
- Total run is L2·(L1+3) + L3·(L2+3) cycles. For the defaults that is 62. `finished` is first high 62 cycles after the enable-sampling edge.
- All outputs are registered.

## Configuration
- `FC_RELU_EN` defined: `act_wr_data` = max(0, `mac_acc`).
- Undefined: `act_wr_data` = raw `mac_acc`.
- Arg-max always uses raw `mac_acc`.

## Structure
- Package `fc_ctrl_pkg`:
  - FSM state enum
  - ReLU function
  - layer-size derived constants (total weights, in_base per layer)
- Sub-module `fc_argmax`: running max value and index registers, clear-on-first and update strobes, strict-greater compare.

## Test plan
- Reset held low → every output at its reset value. Release with `enable`=0 → stays IDLE, `rd_en`=0.
- Default sizes, model MAC, output acc largest at class 0 → `finished` at cycle 62, `result`=0, 26 distinct `w_addr` values 0..25.
- Output accs all equal → `result`=0. Class 7 uniquely largest → `result`=7. Class 9 largest (last node) → `result`=9.
- Hidden `mac_acc`=−5 → `act_wr_data`=0 with `FC_RELU_EN`, 0xFFFB without. `act_wr_addr`=3, then 4.
- `reset` low at cycle 20 → outputs at reset values the same cycle. Re-enable → `w_addr` restarts at 0, full run completes in 62 cycles.
- `enable` held high in DONE → `finished` stays 1. Drop `enable` → IDLE and `finished`=0 next cycle. Re-raise → new run.
